// File: rtl/mult_unit_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mult_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int PROD_W     = 64;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Two's-complement magnitude; 0x80000000 maps to 2^31, which still fits unsigned.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Operand/accumulator registers, shift-add step and final sign correction.
// Signed support compiled in only when MULT_SIGNED_EN is defined.
module mult_datapath
  import mult_unit_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_i,
  input  logic              step_i,
  input  logic              finish_i,
  input  logic              op_signed_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [PROD_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [PROD_W-1:0] acc_q;
  logic [DATA_W-1:0] hi_q, lo_q;

  logic [DATA_W-1:0] mcand_cap, mplier_cap;
  logic              neg_d, neg_q;
  logic [PROD_W-1:0] add_d, acc_d, prod_d;

  // Operand conditioning at capture: magnitudes plus result sign when signed.
  always_comb begin
    mcand_cap  = rs_i;
    mplier_cap = rt_i;
    neg_d      = 1'b0;
`ifdef MULT_SIGNED_EN
    if (op_signed_i) begin
      mcand_cap  = mag(rs_i);
      mplier_cap = mag(rt_i);
      neg_d      = rs_i[DATA_W-1] ^ rt_i[DATA_W-1];
    end
`endif
  end

`ifndef MULT_SIGNED_EN
  logic unused_sign;
  assign unused_sign = op_signed_i;
`endif

  // One step: add shifted multiplicand for each set bit in the low multiplier group.
  always_comb begin
    add_d = '0;
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (mplier_q[b]) add_d = add_d + (mcand_q << b);
    end
    acc_d  = acc_q + add_d;
    prod_d = neg_q ? (~acc_d + 1'b1) : acc_d;
  end

  // Operand/accumulator registers; multiplicand walks left, multiplier walks right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
    end else if (capture_i) begin
      mcand_q  <= {{(PROD_W-DATA_W){1'b0}}, mcand_cap};
      mplier_q <= mplier_cap;
      acc_q    <= '0;
      neg_q    <= neg_d;
    end else if (step_i) begin
      mcand_q  <= mcand_q << BITS_PER_CYCLE;
      mplier_q <= mplier_q >> BITS_PER_CYCLE;
      acc_q    <= acc_d;
    end
  end

  // Result registers: loaded with the final (sign-corrected) sum on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (finish_i) begin
      hi_q <= prod_d[PROD_W-1:DATA_W];
      lo_q <= prod_d[DATA_W-1:0];
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mult_unit.sv
// Iterative multiplier top: FSM, iteration counter and register-file write-back.
// MULT_SIGNED_EN enables signed operation selected by op_signed.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op_signed,
  input  logic [DATA_W-1:0]     rs_data,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic                  wb_en
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [REG_ADDR_W-1:0]   dest_q;
  logic                    capture, step, finish;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath strobes; start is only looked at outside RUN.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          capture = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Iteration counter and latched destination register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      dest_q <= ZERO_REG;
    end else if (capture) begin
      cnt_q  <= '0;
      dest_q <= dest_reg;
    end else if (step) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  mult_datapath #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_dp (
    .clk        (clk),
    .rst        (reset),
    .capture_i  (capture),
    .step_i     (step),
    .finish_i   (finish),
    .op_signed_i(op_signed),
    .rs_i       (rs_data),
    .rt_i       (rt_data),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  // Outputs decode registered state only; register 0 is never written.
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign wb_en   = done && (dest_q != ZERO_REG);
  assign wb_reg  = dest_q;
  assign wb_data = lo;

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative 32x32 shift-add multiplier sitting directly downstream of the register file read ports. It consumes the two read-data buses (rs/rt operands), computes a 64-bit product over multiple cycles into HI/LO, and produces a one-cycle write-back request (LO into a destination register) that drives the register file write port. It runs in parallel with the rest of the datapath; control stalls dependent instructions on `busy`.

## Interface
- BITS_PER_CYCLE, 1, multiplier bits retired per cycle; legal values 1, 2, 4; N = 32/BITS_PER_CYCLE iterations
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled only in IDLE or DONE
- op_signed  in  1  1 = signed multiply; honoured only when the configuration macro is defined
- rs_data  in  32  multiplicand (register file ReadData1)
- rt_data  in  32  multiplier (register file ReadData2)
- dest_reg  in  5  write-back destination, captured with operands
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse, result valid
- hi  out  32  product bits 63:32
- lo  out  32  product bits 31:0
- wb_data  out  32  to register file WriteData; equals lo
- wb_reg  out  5  to register file WriteRegister
- wb_en  out  1  to register file RegWrite

## Operation
- FSM states: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE/DONE + start=1: capture rs_data, rt_data, dest_reg, op_signed; clear accumulator; iteration counter = 0; -> RUN. Without start: DONE -> IDLE, IDLE holds.
- RUN: each cycle add (multiplicand << shift) per multiplier bit group into 64-bit accumulator; counter += 1; after N iterations -> DONE, hi/lo loaded from accumulator (sign-corrected).
- start in RUN ignored; no queueing.
- Operands are latched; rs_data/rt_data/dest_reg may change after the start cycle without effect.
- Arithmetic: unsigned magnitudes, 64-bit accumulator, no overflow possible. Magnitude of 0x80000000 is 2^31 and fits 32 unsigned bits.
- wb_en = done AND captured dest_reg != 0 (register 0 never written). wb_reg = captured dest_reg; wb_data = lo.
- hi/lo hold last result until the next DONE entry.
- Reset (any time, incl. mid-RUN): state IDLE; busy, done, wb_en = 0; hi, lo, wb_data = 0; wb_reg = 0; no write-back issued for the aborted operation.

## Timing
- start high in cycle 0 (accepted at edge ending cycle 0).
- busy = 1 in cycles 1..N; 0 otherwise.
- done, wb_en high exactly in cycle N+1 (BITS_PER_CYCLE=1: cycle 33); hi/lo valid from cycle N+1.
- start asserted in cycle N+1 is accepted; next done at cycle 2N+2. Back-to-back throughput one result per N+1 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- MULT_SIGNED_EN defined: op_signed=1 -> operands converted to magnitudes at capture, 64-bit product two's-complement negated when entering DONE if operand signs differ; op_signed=0 -> unsigned.
- MULT_SIGNED_EN undefined: op_signed ignored, every operation unsigned; sign logic absent.

## Structure
- Shared package: FSM state encoding (IDLE/RUN/DONE), DATA_W = 32, PROD_W = 64, REG_ADDR_W = 5, ZERO_REG = 5'd0.
- One sub-module: mult_datapath (operand/accumulator registers, shift-add step, sign correction); mult_unit holds FSM, counter, write-back outputs.

## Test plan
- Reset, then start with rs=3, rt=5, dest=7 -> busy cycles 1..32, done/wb_en cycle 33, hi=0, lo=15, wb_reg=7, wb_data=15.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- MULT_SIGNED_EN, op_signed=1: 0xFFFFFFFF x 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0; without macro same first stimulus -> hi=0x00000001, lo=0xFFFFFFFE.
- dest_reg=0, 7x6 -> done pulses, lo=42, wb_en stays 0.
- start re-asserted in cycle 10 with different operands -> ignored, first result unaltered; start in cycle 33 -> accepted, second done in cycle 66.
- reset asserted in cycle 12 of a 9x9 operation -> busy/done/wb_en/hi/lo = 0 immediately, no done afterwards, FSM accepts new start after reset release.
